// File: rtl/sha_wb_frontend.sv
// Wishbone register front end for a SHA hash core: message loading, start/clear
// control, digest readout and a level interrupt on completion.
module sha_wb_frontend #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int          MSG_WORDS    = 16,
    parameter int          DIGEST_WORDS = 5
) (
    input  logic                      wb_clk_i,
    input  logic                      reset_n,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic                      core_start,
    output logic [32*MSG_WORDS-1:0]   core_msg,
    input  logic                      core_done,
    input  logic [32*DIGEST_WORDS-1:0] core_digest,
    input  logic [6:0]                core_round,
    output logic                      irq
);
    localparam logic [31:0] ID_VALUE = 32'h53484131;
    localparam logic [31:0] BAD_READ = 32'hFFFFFFEA;
    localparam logic [5:0]  MSG_LAST = 6'(MSG_WORDS - 1);
    localparam logic [3:0]  DIG_LAST = 4'(DIGEST_WORDS - 1);

    localparam logic [2:0] REG_NR      = 3'd0;
    localparam logic [2:0] REG_ID      = 3'd1;
    localparam logic [2:0] REG_MSG_IN  = 3'd2;
    localparam logic [2:0] REG_MSG_IDX = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam logic [2:0] REG_DIGEST  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] msg_q [MSG_WORDS];
    logic [31:0] msg_d [MSG_WORDS];
    logic [31:0] dig_q [DIGEST_WORDS];
    logic [31:0] dig_d [DIGEST_WORDS];
    logic [5:0]  msg_idx_q, msg_idx_d;
    logic [3:0]  dig_idx_q, dig_idx_d;
    logic        auto_q, auto_d, irq_en_q, irq_en_d;
    logic        err_q, err_d, irq_q, irq_d;
    logic        ack_q, ack_d, start_q, start_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] offset;
    logic        hit, req, wr, rd;
    logic [2:0]  reg_sel;
    logic [31:0] status_word, dig_word;

    assign offset  = wbs_adr_i - BASE_ADDRESS;
    assign hit     = (offset < 32'h1C) && (offset[1:0] == 2'b00);
    assign reg_sel = offset[4:2];
    // ~ack_q keeps a held strobe from being acked on back-to-back cycles
    assign req     = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
    assign wr      = req & wbs_we_i & (wbs_sel_i == 4'hF);
    assign rd      = req & ~wbs_we_i;

    always_comb begin
        status_word        = '0;
        status_word[0]     = (state_q == S_RUN);
        status_word[1]     = (state_q == S_DONE);
        status_word[2]     = err_q;
        status_word[3]     = irq_q;
        status_word[5:4]   = state_q;
        status_word[14:8]  = core_round;
        status_word[21:16] = msg_idx_q;
        dig_word = '0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (dig_idx_q == 4'(i)) dig_word = dig_q[i];
        end
    end

    always_comb begin
        logic start_fire;
        logic clear_req;
        state_d   = state_q;
        msg_d     = msg_q;
        dig_d     = dig_q;
        msg_idx_d = msg_idx_q;
        dig_idx_d = dig_idx_q;
        auto_d    = auto_q;
        irq_en_d  = irq_en_q;
        err_d     = err_q;
        irq_d     = irq_q;
        ack_d     = req;
        start_d   = 1'b0;
        dat_d     = dat_q;
        start_fire = 1'b0;
        clear_req  = 1'b0;

        if (rd) begin
            case (reg_sel)
                REG_NR:      dat_d = 32'd7;
                REG_ID:      dat_d = ID_VALUE;
                REG_MSG_IN:  dat_d = BAD_READ;
                REG_MSG_IDX: dat_d = {26'd0, msg_idx_q};
                REG_CTRL:    dat_d = {28'd0, irq_en_q, auto_q, 2'b00};
                REG_STATUS: begin
                    dat_d = status_word;
                    irq_d = 1'b0;
                end
                REG_DIGEST: begin
                    if (state_q == S_DONE) begin
                        dat_d     = dig_word;
                        dig_idx_d = (dig_idx_q == DIG_LAST) ? 4'd0 : dig_idx_q + 4'd1;
                    end else begin
                        dat_d = BAD_READ;
                    end
                end
                default: dat_d = dat_q;
            endcase
        end

        if (wr) begin
            case (reg_sel)
                REG_MSG_IN: begin
                    if (state_q == S_RUN) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < MSG_WORDS; i++) begin
                            if (msg_idx_q == 6'(i)) msg_d[i] = wbs_dat_i;
                        end
                        msg_idx_d = (msg_idx_q == MSG_LAST) ? 6'd0 : msg_idx_q + 6'd1;
                        state_d   = S_LOAD;
                        if (auto_q && (msg_idx_q == MSG_LAST)) start_fire = 1'b1;
                    end
                end
                REG_MSG_IDX: msg_idx_d = 6'(wbs_dat_i % 32'(MSG_WORDS));
                REG_CTRL: begin
                    auto_d    = wbs_dat_i[2];
                    irq_en_d  = wbs_dat_i[3];
                    clear_req = wbs_dat_i[1];
                    if (!wbs_dat_i[3]) irq_d = 1'b0;
                    if (wbs_dat_i[0]) begin
                        if (state_q == S_RUN) err_d = 1'b1;
                        else                  start_fire = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (start_fire) begin
            state_d = S_RUN;
            start_d = 1'b1;
        end

        if (core_done && (state_q == S_RUN)) begin
            for (int i = 0; i < DIGEST_WORDS; i++) dig_d[i] = core_digest[32*i +: 32];
            dig_idx_d = 4'd0;
            state_d   = S_DONE;
            if (irq_en_d) irq_d = 1'b1;
        end

        // CLEAR overrides every other event in the same cycle
        if (clear_req) begin
            state_d   = S_IDLE;
            for (int i = 0; i < MSG_WORDS; i++)    msg_d[i] = '0;
            for (int i = 0; i < DIGEST_WORDS; i++) dig_d[i] = '0;
            msg_idx_d = '0;
            dig_idx_d = '0;
            err_d     = 1'b0;
            irq_d     = 1'b0;
            start_d   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < MSG_WORDS; i++)    msg_q[i] <= '0;
            for (int i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
            msg_idx_q <= '0;
            dig_idx_q <= '0;
            auto_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            start_q   <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < MSG_WORDS; i++)    msg_q[i] <= msg_d[i];
            for (int i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= dig_d[i];
            msg_idx_q <= msg_idx_d;
            dig_idx_q <= dig_idx_d;
            auto_q    <= auto_d;
            irq_en_q  <= irq_en_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            dat_q     <= dat_d;
        end
    end

    generate
        for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_msg
            assign core_msg[32*gi +: 32] = msg_q[gi];
        end
    endgenerate

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign core_start = start_q;
    assign irq        = irq_q;
endmodule
